// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit,
// tags returned words with their PC and buffers them in an in-order FIFO.
// A redirect flushes the FIFO and arranges for in-flight responses to be dropped.
module inst_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_occ;
  logic [CW-1:0]         r_out;
  logic [CW-1:0]         r_drop;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_inst_mem [DEPTH];

  logic [CW:0]           w_inflight;
  logic                  w_req_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_redirect_pc;

  // Handshakes and credit check; the FIFO head is read straight from storage
  always_comb begin
    w_inflight     = {1'b0, r_occ} + {1'b0, r_out};
    imem_req_valid = rstn & ~redirect & (w_inflight < (CW+1)'(DEPTH));
    imem_req_addr  = r_fetch_pc;
    w_req_fire     = imem_req_valid & imem_req_ready;
    inst_valid     = rstn & (r_occ != '0);
    inst_out       = r_inst_mem[r_rd_ptr];
    inst_pc        = r_pc_mem[r_rd_ptr];
    w_pop          = inst_valid & inst_ready;
    w_push         = rstn & ~redirect & imem_resp_valid & (r_drop == '0);
    w_redirect_pc  = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  end

  // Control state: PCs, counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_occ      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect) begin
      // A response landing in the redirect cycle is stale, so it leaves the
      // drop count as well as the outstanding count.
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_occ      <= '0;
      r_out      <= r_out - CW'(imem_resp_valid);
      r_drop     <= r_out - CW'(imem_resp_valid);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_out <= r_out + CW'(w_req_fire) - CW'(imem_resp_valid);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      if (w_req_fire)
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
      if (imem_resp_valid && r_drop != '0)
        r_drop <= r_drop - CW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + DATA_WIDTH'(4);
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // FIFO storage, written on push only
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_resp_pc;
      r_inst_mem[r_wr_ptr] <= imem_resp_data;
    end
  end

  // Credit invariants: no push into a full FIFO, no response without a request
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(w_push && r_occ == CW'(DEPTH)));
      assert (!(imem_resp_valid && r_out == '0));
    end
  end

endmodule
